// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device byte transmitter (inhibit, request, shift with odd parity, ACK check) driving open-drain oe pins
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       busy,
  output logic       done,
  output logic       ack_ok,
  output logic       error
);
  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IW-1:0] I_LAST = IW'(INHIBIT_CYCLES - 1);
  localparam logic [FW-1:0] F_LAST = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
  typedef enum logic [2:0] {IDLE, INHIBIT, REQ, SEND, ACK, WAITIDLE, DONE} state_t;
  state_t state, state_nx;
  logic [1:0] clk_sync, data_sync;
  logic clk_f, clk_f_d, fall, data_s, timeout, data_bit, nack;
  logic [FW-1:0] fcnt;
  logic [IW-1:0] icnt;
  logic [TW-1:0] tcnt;
  logic [3:0] n;
  logic [9:0] drv;
  always_comb begin
    data_s = data_sync[1];
    fall = clk_f_d & ~clk_f;
    timeout = (state == SEND || state == ACK) && tcnt == T_LAST;
    busy = state != IDLE;
    done = state == DONE;
    ps2_clk_oe = state == INHIBIT || state == REQ;
    ps2_data_oe = state == REQ || (state == SEND && data_bit);
    state_nx = state;
    case (state)
      IDLE:     state_nx = tx_start ? INHIBIT : IDLE;
      INHIBIT:  state_nx = icnt == I_LAST ? REQ : INHIBIT;
      REQ:      state_nx = SEND;
      SEND:     state_nx = timeout ? DONE : (fall && n == 4'd9) ? ACK : SEND;
      ACK:      state_nx = timeout ? DONE : fall ? WAITIDLE : ACK;
      WAITIDLE: state_nx = (clk_f && data_s) ? DONE : WAITIDLE;
      DONE:     state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      clk_sync <= 2'b11;
      data_sync <= 2'b11;
      clk_f <= 1'b1;
      clk_f_d <= 1'b1;
      fcnt <= '0;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk_in};
      data_sync <= {data_sync[0], ps2_data_in};
      clk_f_d <= clk_f;
      if (clk_sync[1] == clk_f) fcnt <= '0;
      else if (fcnt == F_LAST) begin
        clk_f <= clk_sync[1];
        fcnt <= '0;
      end else fcnt <= fcnt + 1'b1;
    end
  // drv holds the pin-drive values for edges 1..10: inverted data, inverted odd parity, released stop
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      icnt <= '0;
      tcnt <= '0;
      n <= '0;
      drv <= '0;
      data_bit <= 1'b0;
      nack <= 1'b0;
      ack_ok <= 1'b0;
      error <= 1'b0;
    end else begin
      icnt <= state == INHIBIT ? icnt + 1'b1 : '0;
      tcnt <= (state == SEND || state == ACK) ? tcnt + 1'b1 : '0;
      if (state == IDLE && tx_start) begin
        drv <= {1'b0, ^tx_data, ~tx_data};
        n <= '0;
        nack <= 1'b0;
        ack_ok <= 1'b0;
        error <= 1'b0;
      end
      if (state == REQ) data_bit <= 1'b1;
      if (state == SEND && fall) begin
        data_bit <= drv[0];
        drv <= {1'b0, drv[9:1]};
        n <= n + 1'b1;
      end
      if (state == ACK && fall) nack <= data_s;
      if (state != DONE && state_nx == DONE) begin
        ack_ok <= ~(timeout | nack);
        error <= timeout | nack;
      end
    end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: scoreboard bench with a PS/2 device model for ps2_host_tx
module tb_ps2_host_tx;
  localparam int INH = 50;
  localparam int TO = 3000;
  localparam int HP = 40;
  logic clk = 1'b0, rst = 1'b1;
  logic dev_clk = 1'b1, dev_data = 1'b1;
  logic ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe;
  logic [7:0] tx_data = 8'h00;
  logic tx_start = 1'b0;
  logic busy, done, ack_ok, error;
  int n_chk = 0, n_pass = 0;
  logic bit_q[$];
  logic [1:0] res_q[$];
  always #5 clk = ~clk;
  assign ps2_clk_in = dev_clk & ~ps2_clk_oe;
  assign ps2_data_in = dev_data & ~ps2_data_oe;
  ps2_host_tx #(.INHIBIT_CYCLES(INH), .FILTER_LEN(8), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe), .tx_data(tx_data),
    .tx_start(tx_start), .busy(busy), .done(done), .ack_ok(ack_ok), .error(error)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  always @(negedge clk)
    if (done) begin
      if (res_q.size() == 0) chk("done_unexpected", 1, 0);
      else begin
        logic [1:0] r;
        r = res_q.pop_front();
        chk("ack_ok", ack_ok, r[1]);
        chk("error", error, r[0]);
      end
    end
  task automatic dev_frame(input logic nack, input logic glitch, input logic abort);
    int w = 0;
    logic early = 1'b0;
    while (!(ps2_data_oe && !ps2_clk_oe) && w < INH + 50) begin
      @(negedge clk);
      w++;
    end
    chk("req_seen", ps2_data_oe & ~ps2_clk_oe, 1);
    if (!(ps2_data_oe && !ps2_clk_oe)) return;
    for (int k = 1; k <= 11; k++) begin
      repeat (HP) @(negedge clk);
      if (k == 11) dev_data = nack;
      dev_clk = 1'b0;
      repeat (HP) @(negedge clk);
      if (k <= 10) chk($sformatf("bit%0d", k), ps2_data_oe, bit_q.pop_front());
      if (abort && k == 5) begin
        #1 rst = 1'b1;
        #1 chk("rst_async_oe", {ps2_clk_oe, ps2_data_oe}, 0);
        dev_clk = 1'b1;
        bit_q.delete();
        repeat (4) @(negedge clk);
        chk("rst_outputs", {ps2_clk_oe, ps2_data_oe, busy, done, ack_ok, error}, 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("idle_after_rst", {busy, done, ack_ok, error}, 0);
        return;
      end
      dev_clk = 1'b1;
      if (glitch && k == 4) begin
        repeat (HP / 2) @(negedge clk);
        dev_clk = 1'b0;
        repeat (3) @(negedge clk);
        dev_clk = 1'b1;
      end
    end
    if (!nack) begin
      repeat (HP) begin
        @(negedge clk);
        if (done) early = 1'b1;
      end
      chk("done_before_idle", early, 0);
      dev_data = 1'b1;
    end
  endtask
  task automatic wait_done(input int bound);
    int w = 0;
    while (!done && w < bound) begin
      @(negedge clk);
      w++;
    end
    chk("done_seen", done, 1);
    if (done) begin
      chk("oe_at_done", {ps2_clk_oe, ps2_data_oe}, 0);
      @(negedge clk);
      chk("busy_done_after", {busy, done}, 0);
    end
  endtask
  // mode: 0 ACK, 1 NACK, 2 silent device, 3 glitch plus ignored second start, 4 reset mid-frame
  task automatic xfer(input logic [7:0] d, input int mode);
    int hi, inh;
    if (mode != 2) begin
      for (int i = 0; i < 8; i++) bit_q.push_back(~d[i]);
      bit_q.push_back(($countones(d) % 2) == 1);
      bit_q.push_back(1'b0);
    end
    if (mode != 4) res_q.push_back((mode == 0 || mode == 3) ? 2'b10 : 2'b01);
    tx_data = d;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    chk("busy_t1", busy, 1);
    chk("clk_oe_t1", ps2_clk_oe, 1);
    fork
      begin
        hi = 1;
        inh = ps2_data_oe ? 0 : 1;
        while (ps2_clk_oe && hi < INH + 20) begin
          @(negedge clk);
          if (ps2_clk_oe) hi++;
          if (ps2_clk_oe && !ps2_data_oe) inh++;
        end
        chk("clk_oe_high_cycles", hi, INH + 1);
        chk("inhibit_cycles", inh, INH);
        if (mode == 3) begin
          repeat (200) @(negedge clk);
          tx_data = 8'h5A;
          tx_start = 1'b1;
          @(negedge clk);
          tx_start = 1'b0;
        end
      end
      if (mode != 2) dev_frame(mode == 1, mode == 3, mode == 4);
    join
    if (mode != 4) wait_done(TO + 2000);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("reset_outputs", {ps2_clk_oe, ps2_data_oe, busy, done, ack_ok, error}, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("idle_outputs", {ps2_clk_oe, ps2_data_oe, busy, done}, 0);
    xfer(8'hF4, 0);
    xfer(8'h00, 0);
    xfer(8'hA5, 1);
    xfer(8'h3C, 2);
    xfer(8'h3C, 3);
    xfer(8'h00, 4);
    xfer(8'hFF, 0);
    repeat (10) @(negedge clk);
    chk("results_consumed", res_q.size(), 0);
    chk("bits_consumed", bit_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
